pkt_formatter: RTL and testbench

PKT_FORMATTER -- requirements
Module: pkt_formatter

---
 rtl/pkt_formatter.sv | 147 ++++++++++++++
 tb/tb_pkt_formatter.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_formatter.sv
// pkt_formatter
//   Collects same-channel payload words from the upstream arbiter into a packet,
//   then emits a header word followed by the buffered payload. A packet closes
//   when it reaches MAX_LEN words, when a word from another channel shows up, or
//   after TIMEOUT idle input cycles following the last accepted word.
//
// Ports
//   clk        in   1   rising-edge clock
//   reset_n    in   1   asynchronous active-low reset
//   in_valid   in   1   upstream word valid
//   in_ready   out  1   word accepted this cycle (combinational in COLLECT)
//   in_data    in   32  upstream payload word
//   in_ch      in   3   source channel of in_data
//   out_valid  out  1   out_data valid
//   out_ready  in   1   downstream accepts out_data
//   out_data   out  32  header or payload word
//   out_sop    out  1   out_data is the header
//   out_eop    out  1   out_data is the last payload word
//
// state   | meaning
// IDLE    | no packet open; ready for the first word of the next packet
// COLLECT | packet open on lock_ch; accepting same-channel words, timing idles
// HEAD    | packet closed; header loaded into the output register, then sent
// BODY    | streaming buffered payload words, eop on the last one

module pkt_formatter #(
  parameter int MAX_LEN = 8,
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic [2:0]  in_ch,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_sop,
  output logic        out_eop
);

  localparam int IW = $clog2(MAX_LEN);

  typedef enum logic [1:0] {IDLE, COLLECT, HEAD, BODY} state_t;

  state_t        state;
  logic [31:0]   pay_mem [MAX_LEN];
  logic [2:0]    lock_ch;
  logic [4:0]    cnt;
  logic [7:0]    timer;
  logic [4:0]    idx;
  logic [4:0]    idx_nxt;
  logic          ready_q;
  logic          accept;
  logic [IW-1:0] wr_ptr;

  // ready_q keeps in_ready low until the first clock edge after reset release.
  always_comb begin
    in_ready = 1'b0;
    case (state)
      IDLE:    in_ready = ready_q;
      COLLECT: in_ready = !(in_valid && (in_ch != lock_ch));
      default: in_ready = 1'b0;
    endcase
  end

  assign accept  = in_valid && in_ready;
  assign idx_nxt = idx + 5'd1;
  assign wr_ptr  = (state == COLLECT) ? cnt[IW-1:0] : '0;

  // Payload storage carries no reset; its contents are only read back for
  // positions written during the current packet.
  always_ff @(posedge clk) begin
    if (accept) pay_mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      ready_q   <= 1'b0;
      lock_ch   <= '0;
      cnt       <= '0;
      timer     <= '0;
      idx       <= '0;
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      out_data  <= '0;
    end else begin
      ready_q <= 1'b1;
      case (state)
        IDLE: begin
          if (accept) begin
            lock_ch <= in_ch;
            cnt     <= 5'd1;
            timer   <= '0;
            state   <= COLLECT;
          end
        end
        COLLECT: begin
          if (accept) begin
            cnt   <= cnt + 5'd1;
            timer <= '0;
            if (cnt + 5'd1 == 5'(MAX_LEN)) state <= HEAD;
          end else if (in_valid) begin
            // Foreign channel: close now, upstream keeps holding that word.
            state <= HEAD;
          end else begin
            timer <= timer + 8'd1;
            if (timer == 8'(TIMEOUT - 1)) state <= HEAD;
          end
        end
        HEAD: begin
          // First HEAD cycle loads the header; it is presented from the next.
          if (!out_valid) begin
            out_valid <= 1'b1;
            out_sop   <= 1'b1;
            out_eop   <= 1'b0;
            out_data  <= {8'hA5, 5'd0, lock_ch, 11'd0, cnt};
          end else if (out_ready) begin
            out_sop  <= 1'b0;
            out_data <= pay_mem[0];
            out_eop  <= (cnt == 5'd1);
            idx      <= '0;
            state    <= BODY;
          end
        end
        BODY: begin
          if (out_ready) begin
            if (out_eop) begin
              out_valid <= 1'b0;
              out_eop   <= 1'b0;
              out_data  <= '0;
              state     <= IDLE;
            end else begin
              idx      <= idx_nxt;
              out_data <= pay_mem[idx_nxt[IW-1:0]];
              out_eop  <= (idx_nxt == cnt - 5'd1);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pkt_formatter.sv
module tb_pkt_formatter;

  localparam int ML_A = 8;
  localparam int TO_A = 16;
  localparam int ML_B = 2;
  localparam int TO_B = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic [31:0] in_data;
  logic [2:0]  in_ch;
  logic        out_ready;

  logic        rdy_a, ov_a, sop_a, eop_a;
  logic [31:0] od_a;
  logic        rdy_b, ov_b, sop_b, eop_b;
  logic [31:0] od_b;

  logic        sel;
  logic        m_in_ready, m_out_valid, m_out_sop, m_out_eop;
  logic [31:0] m_out_data;

  always #5 clk = ~clk;

  pkt_formatter #(.MAX_LEN(ML_A), .TIMEOUT(TO_A)) dut_a (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy_a),
    .in_data(in_data), .in_ch(in_ch), .out_valid(ov_a), .out_ready(out_ready),
    .out_data(od_a), .out_sop(sop_a), .out_eop(eop_a)
  );

  pkt_formatter #(.MAX_LEN(ML_B), .TIMEOUT(TO_B)) dut_b (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy_b),
    .in_data(in_data), .in_ch(in_ch), .out_valid(ov_b), .out_ready(out_ready),
    .out_data(od_b), .out_sop(sop_b), .out_eop(eop_b)
  );

  assign m_in_ready  = sel ? rdy_b : rdy_a;
  assign m_out_valid = sel ? ov_b  : ov_a;
  assign m_out_data  = sel ? od_b  : od_a;
  assign m_out_sop   = sel ? sop_b : sop_a;
  assign m_out_eop   = sel ? eop_b : eop_a;

  typedef struct { logic [31:0] data; logic [2:0] ch; int gap; } word_t;
  typedef struct { int cyc; logic [31:0] data; logic sop; logic eop; } obs_t;
  typedef struct { logic [31:0] data; logic sop; logic eop; } exp_t;

  word_t stim[$];
  obs_t  obs[$];
  exp_t  exp_q[$];
  int    acc_cyc[$];
  logic  rdy_log[$];
  int    stall_viol;
  logic  timed_out;
  int    out_ready_pct;
  int    checks = 0;
  int    failures = 0;

  // Reference: group the stimulus words into packets from the packet rules.
  function automatic void emit_packet(input logic [2:0] ch, input logic [31:0] words[$]);
    exp_q.push_back('{{8'hA5, 5'd0, ch, 11'd0, 5'(words.size())}, 1'b1, 1'b0});
    foreach (words[i]) exp_q.push_back('{words[i], 1'b0, (i == words.size() - 1)});
  endfunction

  function automatic void build_expected(input int ml, input int to);
    logic [31:0] pkt[$];
    logic [2:0]  ch;
    ch = '0;
    exp_q.delete();
    for (int i = 0; i < stim.size(); i++) begin
      if (pkt.size() != 0 && (stim[i].ch != ch || stim[i].gap >= to || pkt.size() == ml)) begin
        emit_packet(ch, pkt);
        pkt.delete();
      end
      if (pkt.size() == 0) ch = stim[i].ch;
      pkt.push_back(stim[i].data);
    end
    if (pkt.size() != 0) emit_packet(ch, pkt);
  endfunction

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    reset_n   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Drives stim (each word held until accepted, gap = idle cycles after the
  // previous accept) and records accepts, in_ready and output transfers.
  task automatic run_traffic(input int max_cycles, input int stop_obs, input int drain);
    int          wi, gapc, dr;
    logic        pend;
    logic [31:0] p_data;
    logic        p_sop, p_eop;
    wi = 0; dr = drain; pend = 1'b0; p_data = '0; p_sop = 1'b0; p_eop = 1'b0;
    obs.delete(); acc_cyc.delete(); rdy_log.delete();
    stall_viol = 0;
    timed_out  = 1'b0;
    gapc = (stim.size() > 0) ? stim[0].gap : 0;
    for (int c = 0; c < max_cycles; c++) begin
      if (wi < stim.size() && gapc == 0) begin
        in_valid = 1'b1; in_data = stim[wi].data; in_ch = stim[wi].ch;
      end else begin
        in_valid = 1'b0; in_data = $urandom; in_ch = 3'($urandom);
      end
      out_ready = (int'($urandom_range(0, 99)) < out_ready_pct);
      @(negedge clk);
      rdy_log.push_back(m_in_ready);
      if (pend && (m_out_valid !== 1'b1 || m_out_data !== p_data ||
                   m_out_sop !== p_sop || m_out_eop !== p_eop))
        stall_viol++;
      pend = m_out_valid && !out_ready;
      p_data = m_out_data; p_sop = m_out_sop; p_eop = m_out_eop;
      if (in_valid && m_in_ready) begin
        acc_cyc.push_back(c);
        wi++;
        if (wi < stim.size()) gapc = stim[wi].gap;
      end else if (!in_valid && gapc > 0) begin
        gapc--;
      end
      if (m_out_valid && out_ready) obs.push_back('{c, m_out_data, m_out_sop, m_out_eop});
      @(posedge clk);
      #1;
      if (wi == stim.size() && obs.size() >= stop_obs) begin
        if (dr == 0) return;
        dr--;
      end
    end
    timed_out = 1'b1;
  endtask

  task automatic test_reset();
    sel = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b0; in_valid = 1'b1; in_ch = 3'd5; out_ready = 1'b1;
    #1;
    checks++; if (m_in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready: got %b expected 0", m_in_ready); end
    checks++; if (m_out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", m_out_valid); end
    checks++; if ({m_out_sop, m_out_eop} !== 2'b00) begin failures++; $display("FAIL reset_sop_eop: got %b expected 00", {m_out_sop, m_out_eop}); end
    checks++; if (m_out_data !== 32'h0) begin failures++; $display("FAIL reset_out_data: got %h expected 0", m_out_data); end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    checks++; if (m_in_ready !== 1'b0) begin failures++; $display("FAIL release_before_edge: got %b expected 0", m_in_ready); end
    @(posedge clk); #1;
    checks++; if (m_in_ready !== 1'b1) begin failures++; $display("FAIL release_after_edge: got %b expected 1", m_in_ready); end
    in_valid = 1'b0;
  endtask

  task automatic test_full_packet();
    int bad;
    sel = 1'b0; do_reset();
    stim.delete();
    for (int i = 0; i < 8; i++) stim.push_back('{$urandom, 3'd2, 0});
    out_ready_pct = 100;
    build_expected(ML_A, TO_A);
    run_traffic(400, exp_q.size(), 20);
    checks++; if (timed_out !== 1'b0) begin failures++; $display("FAIL full_budget: got timeout expected completion"); end
    checks++; if (obs.size() !== exp_q.size()) begin failures++; $display("FAIL full_count: got %0d expected %0d", obs.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs.size()) begin
      checks++;
      if ({obs[i].sop, obs[i].eop, obs[i].data} !== {exp_q[i].sop, exp_q[i].eop, exp_q[i].data}) begin
        failures++; $display("FAIL full_word[%0d]: got %h expected %h", i, {obs[i].sop, obs[i].eop, obs[i].data}, {exp_q[i].sop, exp_q[i].eop, exp_q[i].data});
      end
    end
    if (acc_cyc.size() == 8 && obs.size() == 9) begin
      checks++; if (obs[0].data !== 32'hA5020008) begin failures++; $display("FAIL full_header: got %h expected a5020008", obs[0].data); end
      checks++; if (obs[0].cyc - acc_cyc[7] !== 2) begin failures++; $display("FAIL full_head_latency: got %0d expected 2", obs[0].cyc - acc_cyc[7]); end
      checks++; if (obs[8].cyc - obs[0].cyc !== 8) begin failures++; $display("FAIL full_burst_span: got %0d expected 8", obs[8].cyc - obs[0].cyc); end
      bad = 0;
      for (int c = acc_cyc[7] + 1; c <= obs[8].cyc; c++) if (rdy_log[c] !== 1'b0) bad++;
      checks++; if (bad !== 0) begin failures++; $display("FAIL full_in_ready_low: got %0d high cycles expected 0", bad); end
    end
  endtask

  task automatic test_channel_switch();
    sel = 1'b0; do_reset();
    stim.delete();
    for (int i = 0; i < 3; i++) stim.push_back('{$urandom, 3'd1, 0});
    stim.push_back('{$urandom, 3'd4, 0});
    out_ready_pct = 100;
    build_expected(ML_A, TO_A);
    run_traffic(400, exp_q.size(), 20);
    checks++; if (timed_out !== 1'b0) begin failures++; $display("FAIL switch_budget: got timeout expected completion"); end
    checks++; if (obs.size() !== exp_q.size()) begin failures++; $display("FAIL switch_count: got %0d expected %0d", obs.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs.size()) begin
      checks++;
      if ({obs[i].sop, obs[i].eop, obs[i].data} !== {exp_q[i].sop, exp_q[i].eop, exp_q[i].data}) begin
        failures++; $display("FAIL switch_word[%0d]: got %h expected %h", i, {obs[i].sop, obs[i].eop, obs[i].data}, {exp_q[i].sop, exp_q[i].eop, exp_q[i].data});
      end
    end
    if (obs.size() >= 4 && acc_cyc.size() == 4) begin
      checks++; if (obs[0].data !== 32'hA5010003) begin failures++; $display("FAIL switch_header: got %h expected a5010003", obs[0].data); end
      checks++; if (acc_cyc[3] !== obs[3].cyc + 1) begin failures++; $display("FAIL switch_accept_cycle: got %0d expected %0d", acc_cyc[3], obs[3].cyc + 1); end
    end
  endtask

  task automatic test_timeout();
    int sops;
    sel = 1'b0; do_reset();
    stim.delete();
    stim.push_back('{$urandom, 3'd0, 0});
    stim.push_back('{$urandom, 3'd0, 0});
    out_ready_pct = 100;
    build_expected(ML_A, TO_A);
    run_traffic(400, exp_q.size(), 20);
    checks++; if (timed_out !== 1'b0) begin failures++; $display("FAIL tmo_budget: got timeout expected completion"); end
    checks++; if (obs.size() !== exp_q.size()) begin failures++; $display("FAIL tmo_count: got %0d expected %0d", obs.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs.size()) begin
      checks++;
      if ({obs[i].sop, obs[i].eop, obs[i].data} !== {exp_q[i].sop, exp_q[i].eop, exp_q[i].data}) begin
        failures++; $display("FAIL tmo_word[%0d]: got %h expected %h", i, {obs[i].sop, obs[i].eop, obs[i].data}, {exp_q[i].sop, exp_q[i].eop, exp_q[i].data});
      end
    end
    if (obs.size() > 0 && acc_cyc.size() == 2) begin
      checks++; if (obs[0].data !== 32'hA5000002) begin failures++; $display("FAIL tmo_header: got %h expected a5000002", obs[0].data); end
      checks++; if (obs[0].cyc - acc_cyc[1] !== TO_A + 2) begin failures++; $display("FAIL tmo_latency: got %0d expected %0d", obs[0].cyc - acc_cyc[1], TO_A + 2); end
    end
    // Idle gap of TIMEOUT-1 keeps the packet open, TIMEOUT closes it.
    do_reset();
    stim.delete();
    stim.push_back('{$urandom, 3'd6, 0});
    stim.push_back('{$urandom, 3'd6, TO_A - 1});
    stim.push_back('{$urandom, 3'd6, TO_A});
    build_expected(ML_A, TO_A);
    run_traffic(400, exp_q.size(), 20);
    checks++; if (timed_out !== 1'b0) begin failures++; $display("FAIL tmo_edge_budget: got timeout expected completion"); end
    checks++; if (obs.size() !== exp_q.size()) begin failures++; $display("FAIL tmo_edge_count: got %0d expected %0d", obs.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs.size()) begin
      checks++;
      if ({obs[i].sop, obs[i].eop, obs[i].data} !== {exp_q[i].sop, exp_q[i].eop, exp_q[i].data}) begin
        failures++; $display("FAIL tmo_edge_word[%0d]: got %h expected %h", i, {obs[i].sop, obs[i].eop, obs[i].data}, {exp_q[i].sop, exp_q[i].eop, exp_q[i].data});
      end
    end
    sops = 0;
    foreach (obs[i]) if (obs[i].sop) sops++;
    checks++; if (sops !== 2) begin failures++; $display("FAIL tmo_edge_packets: got %0d expected 2", sops); end
  endtask

  task automatic test_stall_random();
    logic [2:0] ch;
    int r, g;
    sel = 1'b0;
    for (int run = 0; run < 3; run++) begin
      do_reset();
      stim.delete();
      ch = 3'($urandom);
      for (int i = 0; i < 30; i++) begin
        if ($urandom_range(0, 3) == 0) ch = 3'($urandom);
        r = int'($urandom_range(0, 9));
        g = (r < 6) ? 0 : (r < 8) ? int'($urandom_range(1, TO_A - 1)) : int'($urandom_range(TO_A, TO_A + 8));
        stim.push_back('{$urandom, ch, g});
      end
      out_ready_pct = 50;
      build_expected(ML_A, TO_A);
      run_traffic(4000, exp_q.size(), 30);
      checks++; if (timed_out !== 1'b0) begin failures++; $display("FAIL stall_budget[%0d]: got timeout expected completion", run); end
      checks++; if (obs.size() !== exp_q.size()) begin failures++; $display("FAIL stall_count[%0d]: got %0d expected %0d", run, obs.size(), exp_q.size()); end
      foreach (exp_q[i]) if (i < obs.size()) begin
        checks++;
        if ({obs[i].sop, obs[i].eop, obs[i].data} !== {exp_q[i].sop, exp_q[i].eop, exp_q[i].data}) begin
          failures++; $display("FAIL stall_word[%0d]: got %h expected %h", i, {obs[i].sop, obs[i].eop, obs[i].data}, {exp_q[i].sop, exp_q[i].eop, exp_q[i].data});
        end
      end
      checks++; if (stall_viol !== 0) begin failures++; $display("FAIL stall_hold[%0d]: got %0d changes expected 0", run, stall_viol); end
    end
  endtask

  task automatic test_reset_mid_body();
    sel = 1'b0; do_reset();
    stim.delete();
    for (int i = 0; i < 8; i++) stim.push_back('{$urandom, 3'd3, 0});
    out_ready_pct = 100;
    // Header plus three payload transfers leaves idx=3 on the output.
    run_traffic(400, 4, 0);
    checks++; if ({m_out_valid, m_out_data} !== {1'b1, stim[3].data}) begin failures++; $display("FAIL rst_body_setup: got %h expected %h", {m_out_valid, m_out_data}, {1'b1, stim[3].data}); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (m_out_valid !== 1'b0) begin failures++; $display("FAIL rst_body_valid: got %b expected 0", m_out_valid); end
    checks++; if ({m_out_sop, m_out_eop, m_out_data} !== 34'h0) begin failures++; $display("FAIL rst_body_outputs: got %h expected 0", {m_out_sop, m_out_eop, m_out_data}); end
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    stim.delete();
    for (int i = 0; i < 2; i++) stim.push_back('{$urandom, 3'd7, 0});
    build_expected(ML_A, TO_A);
    run_traffic(400, exp_q.size(), 20);
    checks++; if (timed_out !== 1'b0) begin failures++; $display("FAIL rst_after_budget: got timeout expected completion"); end
    checks++; if (obs.size() !== exp_q.size()) begin failures++; $display("FAIL rst_after_count: got %0d expected %0d", obs.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs.size()) begin
      checks++;
      if ({obs[i].sop, obs[i].eop, obs[i].data} !== {exp_q[i].sop, exp_q[i].eop, exp_q[i].data}) begin
        failures++; $display("FAIL rst_after_word[%0d]: got %h expected %h", i, {obs[i].sop, obs[i].eop, obs[i].data}, {exp_q[i].sop, exp_q[i].eop, exp_q[i].data});
      end
    end
    if (obs.size() > 0) begin
      checks++; if (obs[0].data !== 32'hA5070002) begin failures++; $display("FAIL rst_after_header: got %h expected a5070002", obs[0].data); end
    end
  endtask

  task automatic test_back_to_back();
    sel = 1'b0; do_reset();
    stim.delete();
    for (int i = 0; i < 16; i++) stim.push_back('{$urandom, 3'd5, 0});
    out_ready_pct = 100;
    build_expected(ML_A, TO_A);
    run_traffic(400, exp_q.size(), 20);
    checks++; if (timed_out !== 1'b0) begin failures++; $display("FAIL b2b_budget: got timeout expected completion"); end
    checks++; if (obs.size() !== exp_q.size()) begin failures++; $display("FAIL b2b_count: got %0d expected %0d", obs.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs.size()) begin
      checks++;
      if ({obs[i].sop, obs[i].eop, obs[i].data} !== {exp_q[i].sop, exp_q[i].eop, exp_q[i].data}) begin
        failures++; $display("FAIL b2b_word[%0d]: got %h expected %h", i, {obs[i].sop, obs[i].eop, obs[i].data}, {exp_q[i].sop, exp_q[i].eop, exp_q[i].data});
      end
    end
    if (obs.size() > 8 && acc_cyc.size() > 8) begin
      checks++; if (acc_cyc[8] !== obs[8].cyc + 1) begin failures++; $display("FAIL b2b_idle_gap: got %0d expected %0d", acc_cyc[8], obs[8].cyc + 1); end
    end
  endtask

  task automatic test_small_build();
    int sops;
    sel = 1'b1; do_reset();
    stim.delete();
    for (int i = 0; i < 6; i++) stim.push_back('{$urandom, 3'(i % 2), 0});
    out_ready_pct = 100;
    build_expected(ML_B, TO_B);
    run_traffic(400, exp_q.size(), 20);
    checks++; if (timed_out !== 1'b0) begin failures++; $display("FAIL small_budget: got timeout expected completion"); end
    checks++; if (obs.size() !== exp_q.size()) begin failures++; $display("FAIL small_count: got %0d expected %0d", obs.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs.size()) begin
      checks++;
      if ({obs[i].sop, obs[i].eop, obs[i].data} !== {exp_q[i].sop, exp_q[i].eop, exp_q[i].data}) begin
        failures++; $display("FAIL small_word[%0d]: got %h expected %h", i, {obs[i].sop, obs[i].eop, obs[i].data}, {exp_q[i].sop, exp_q[i].eop, exp_q[i].data});
      end
    end
    sops = 0;
    foreach (obs[i]) if (obs[i].sop) sops++;
    checks++; if (sops !== 6) begin failures++; $display("FAIL small_packets: got %0d expected 6", sops); end
    do_reset();
    stim.delete();
    for (int i = 0; i < 24; i++) stim.push_back('{$urandom, 3'($urandom_range(0, 1)), int'($urandom_range(0, 3))});
    out_ready_pct = 50;
    build_expected(ML_B, TO_B);
    run_traffic(2000, exp_q.size(), 20);
    checks++; if (timed_out !== 1'b0) begin failures++; $display("FAIL small_rand_budget: got timeout expected completion"); end
    checks++; if (obs.size() !== exp_q.size()) begin failures++; $display("FAIL small_rand_count: got %0d expected %0d", obs.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs.size()) begin
      checks++;
      if ({obs[i].sop, obs[i].eop, obs[i].data} !== {exp_q[i].sop, exp_q[i].eop, exp_q[i].data}) begin
        failures++; $display("FAIL small_rand_word[%0d]: got %h expected %h", i, {obs[i].sop, obs[i].eop, obs[i].data}, {exp_q[i].sop, exp_q[i].eop, exp_q[i].data});
      end
    end
    checks++; if (stall_viol !== 0) begin failures++; $display("FAIL small_rand_hold: got %0d changes expected 0", stall_viol); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sel = 1'b0;
    reset_n = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    in_ch = '0;
    out_ready = 1'b0;
    out_ready_pct = 100;
    stall_viol = 0;
    timed_out = 1'b0;
    repeat (2) @(posedge clk);
    test_reset();
    test_full_packet();
    test_channel_switch();
    test_timeout();
    test_stall_random();
    test_reset_mid_body();
    test_back_to_back();
    test_small_build();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
